// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with 2-entry skid, flush and x0 write suppression
// Optional feature macro: PIPE_STATS_EN (stall/flush statistics counters)
module pipe_stage_reg #(
    parameter int PAYLOAD_W     = 128,
    parameter int REG_ADDR_W    = 5,
    parameter int ZERO_ON_FLUSH = 1,
    parameter int CNT_W         = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  flush_in,
    input  logic                  in_valid_in,
    output logic                  in_ready_o,
    input  logic [REG_ADDR_W-1:0] in_rd_addr_in,
    input  logic                  in_rf_wr_en_in,
    input  logic [PAYLOAD_W-1:0]  in_payload_in,
    output logic                  out_valid_o,
    input  logic                  out_ready_in,
    output logic [REG_ADDR_W-1:0] out_rd_addr_o,
    output logic                  out_rf_wr_en_o,
    output logic [PAYLOAD_W-1:0]  out_payload_o,
    output logic [1:0]            occupancy_o
`ifdef PIPE_STATS_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                 state;
    logic                   main_wr_en;
    logic [PAYLOAD_W-1:0]   skid_payload;
    logic [REG_ADDR_W-1:0]  skid_rd_addr;
    logic                   skid_wr_en;
    logic                   in_xfer;
    logic                   out_xfer;

    assign in_xfer  = in_valid_in & in_ready_o;
    assign out_xfer = out_valid_o & out_ready_in;

    assign occupancy_o    = state;
    assign out_rf_wr_en_o = out_valid_o & main_wr_en & (out_rd_addr_o != '0);

    // The main entry is the output register itself, so outputs never pass through a mux.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state         <= EMPTY;
            in_ready_o    <= 1'b1;
            out_valid_o   <= 1'b0;
            out_payload_o <= '0;
            out_rd_addr_o <= '0;
            main_wr_en    <= 1'b0;
            skid_payload  <= '0;
            skid_rd_addr  <= '0;
            skid_wr_en    <= 1'b0;
        end else if (flush_in) begin
            state       <= EMPTY;
            in_ready_o  <= 1'b1;
            out_valid_o <= 1'b0;
            if (ZERO_ON_FLUSH != 0) begin
                out_payload_o <= '0;
                out_rd_addr_o <= '0;
                main_wr_en    <= 1'b0;
                skid_payload  <= '0;
                skid_rd_addr  <= '0;
                skid_wr_en    <= 1'b0;
            end
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) begin
                        out_payload_o <= in_payload_in;
                        out_rd_addr_o <= in_rd_addr_in;
                        main_wr_en    <= in_rf_wr_en_in;
                        out_valid_o   <= 1'b1;
                        state         <= ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        out_payload_o <= in_payload_in;
                        out_rd_addr_o <= in_rd_addr_in;
                        main_wr_en    <= in_rf_wr_en_in;
                    end else if (in_xfer) begin
                        skid_payload <= in_payload_in;
                        skid_rd_addr <= in_rd_addr_in;
                        skid_wr_en   <= in_rf_wr_en_in;
                        in_ready_o   <= 1'b0;
                        state        <= TWO;
                    end else if (out_xfer) begin
                        out_valid_o <= 1'b0;
                        state       <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_xfer) begin
                        out_payload_o <= skid_payload;
                        out_rd_addr_o <= skid_rd_addr;
                        main_wr_en    <= skid_wr_en;
                        in_ready_o    <= 1'b1;
                        state         <= ONE;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    in_ready_o  <= 1'b1;
                    out_valid_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_STATS_EN
    // Both counters saturate so long runs never wrap into misleading small values.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (out_valid_o && !out_ready_in && (stall_cnt_o != '1))
                stall_cnt_o <= stall_cnt_o + 1'b1;
            if (flush_in && (state != EMPTY) && (flush_cnt_o != '1))
                flush_cnt_o <= flush_cnt_o + 1'b1;
        end
    end
`endif

endmodule
